dbg_bus_arbiter: RTL and testbench
==================================

# dbg_bus_arbiter

Shares the core's data-memory bus and register-file debug port between the CPU pipeline and the JTAG debug module. It sequences debug accesses by holding the pipeline, waiting for it to drain, and then granting the bus to the DM. It also turns DM reset requests into a timed core reset pulse. It sits between the JTAG top level (DM side) and the core/bus interconnect, in the `clk` domain.

## Interface
- RST_PULSE_CYCLES, 16: minimum width of the core reset pulse, in `clk` cycles (≥1).
- DRAIN_TIMEOUT, 255: cycles to wait in DRAIN before forcing the grant (≥1, fits in 8 bits).
- clk  in  1  system clock; every flop is clocked on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dm_op_req_i / dm_halt_req_i / dm_reset_req_i  in  1 each  level requests from the DM.
- dm_mem_we_i  in  1; dm_mem_addr_i, dm_mem_wdata_i  in  32; dm_mem_rdata_o  out  32  DM memory port.
- dm_reg_we_i  in  1; dm_reg_addr_i  in  5; dm_reg_wdata_i  in  32; dm_reg_rdata_o  out  32  DM register port.
- core_mem_req_i, core_mem_we_i  in  1; core_mem_addr_i, core_mem_wdata_i  in  32  core memory request.
- core_mem_gnt_o  out  1; core_mem_rdata_o  out  32  core grant and read data.
- core_idle_i  in  1  pipeline drained, no access outstanding.
- core_hold_o  out  1  stall the pipeline.
- core_rst_n_o  out  1  active-low core reset.
- bus_req_o, bus_we_o  out  1; bus_addr_o, bus_wdata_o  out  32; bus_rdata_i  in  32  shared memory bus.
- rf_we_o  out  1; rf_addr_o  out  5; rf_wdata_o  out  32; rf_rdata_i  in  32  register-file debug port.
- dbg_granted_o  out  1  DM currently owns the bus.
- drain_timeout_o  out  1  sticky; set when a grant was forced. Cleared only by `rst_n`.

## Operation
- **States:** IDLE, DRAIN, DEBUG, RELEASE, RESET. The state is held in a register; reset state is IDLE.
- **Priority:** `dm_reset_req_i` beats op/halt requests in every state except RESET.
- **IDLE:** the core owns the bus and `core_hold_o` = 0.
  - `core_mem_gnt_o` = `core_mem_req_i`.
  - Transition to RESET on a reset request, otherwise to DRAIN on `dm_op_req_i` | `dm_halt_req_i`.
- **DRAIN:** `core_hold_o` = 1; the core still owns the bus so in-flight accesses can finish.
  - An 8-bit counter is cleared on entry.
  - Transition to DEBUG when `core_idle_i` = 1.
  - If the counter reaches DRAIN_TIMEOUT, transition to DEBUG anyway and set `drain_timeout_o`.
  - A reset request transitions to RESET.
- **DEBUG:** `core_hold_o` = 1 and `dbg_granted_o` = 1; the bus is muxed to the DM.
  - `bus_req_o` = `dm_op_req_i`; `core_mem_gnt_o` = 0.
  - Transition to RELEASE when `dm_op_req_i` and `dm_halt_req_i` are both low; a reset request transitions to RESET.
- **RELEASE:** lasts one cycle. `core_hold_o` = 1, the bus mux returns to the core, and `bus_req_o` = 0. Next state is IDLE.
- **RESET:** `core_rst_n_o` = 0, `core_hold_o` = 1, `bus_req_o` = 0, `core_mem_gnt_o` = 0.
  - A pulse counter is loaded with RST_PULSE_CYCLES−1 on entry.
  - Exit requires the counter to be 0 and `dm_reset_req_i` to be low. A held request extends the pulse.
  - On exit, go to DRAIN if op/halt is still high, otherwise to IDLE.
- **Register-file port:**
  - `rf_we_o` = `dm_reg_we_i` & `dbg_granted_o`.
  - `rf_addr_o` and `rf_wdata_o` pass through unconditionally.
  - `dm_reg_rdata_o` = `rf_rdata_i`.
- **Read data:** `bus_rdata_i` fans out to both `dm_mem_rdata_o` and `core_mem_rdata_o`. The consumer qualifies the data by its own grant.

## Timing
- **Reset values:**
  - State IDLE; `core_hold_o` 0, `dbg_granted_o` 0, `drain_timeout_o` 0.
  - `core_rst_n_o` 0 while `rst_n` is low. It is registered and becomes 1 on the first `clk` edge after release.
- **Registered outputs:** `core_hold_o`, `dbg_granted_o` and `core_rst_n_o` are decoded from the state register. They change one cycle after the request that causes them.
- **Combinational paths:** the bus mux and the grants are combinational from the state register and the request inputs.
- **Request to grant:** minimum 2 cycles (IDLE→DRAIN→DEBUG, with `core_idle_i` already high). Maximum is DRAIN_TIMEOUT+2 cycles.
- **Release:** op/halt low → `core_hold_o` falls 2 cycles later (DEBUG→RELEASE→IDLE).
- **Reset pulse:** `core_rst_n_o` is low for exactly RST_PULSE_CYCLES cycles when the request is a single-cycle pulse.
- **Bus ownership:** there is never a cycle in which the DM and the core both see ownership. RELEASE is the guard cycle.
- **`rst_n` mid-operation:** asynchronously returns to IDLE, drops the hold, and clears both counters and the sticky flag.

## Structure
- Shared package (`defines.v`) holds:
  - state encodings `DBG_ARB_IDLE`, `DBG_ARB_DRAIN`, `DBG_ARB_DEBUG`, `DBG_ARB_RELEASE`, `DBG_ARB_RESET` (3 bits);
  - `MemAddrBus`/`MemBus` widths (32) and `RegAddrBus` width (5).
- One sub-module: `dbg_pulse_cnt`, a loadable down-counter with a zero flag. It is instantiated twice: once for the drain timeout and once for the reset pulse.

## Test plan
1. `core_idle_i`=1; pulse `dm_op_req_i` with `dm_mem_addr_i`=0x100, `dm_mem_wdata_i`=0xDEADBEEF, we=1 → hold after 1 cycle, grant after 2, bus shows 0x100/0xDEADBEEF, core_mem_gnt_o=0.
2. `core_idle_i` held 0, DRAIN_TIMEOUT=8, halt request → DEBUG entered on cycle 10, `drain_timeout_o`=1 and it stays 1 after release.
3. In DEBUG, `dm_reg_we_i`=1, addr 5, data 0x1234 → `rf_we_o`=1 with addr 5 and data 0x1234. Repeat in IDLE → `rf_we_o`=0.
4. `dm_reset_req_i` single-cycle pulse → `core_rst_n_o` low exactly 16 cycles. Held for 40 cycles → low for 40 cycles, then IDLE.
5. Reset request arriving during DRAIN with halt still high → RESET, then DRAIN after the pulse, then DEBUG. No cycle has both grants asserted.
6. `rst_n` asserted mid-DEBUG → `core_hold_o`=0 and `dbg_granted_o`=0 immediately, `core_rst_n_o`=0, and the state returns to IDLE.

Source files
------------

// File: rtl/dbg_bus_arbiter_pkg.sv
// Shared definitions for the debug bus arbiter.
// Holds the arbiter state encoding, the bus widths and a helper that sizes
// down-counters from their largest load value.
package dbg_bus_arbiter_pkg;

  localparam int MEM_ADDR_BUS = 32;
  localparam int MEM_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int DRAIN_CNT_W  = 8;

  typedef enum logic [2:0] {
    DBG_ARB_IDLE    = 3'd0,
    DBG_ARB_DRAIN   = 3'd1,
    DBG_ARB_DEBUG   = 3'd2,
    DBG_ARB_RELEASE = 3'd3,
    DBG_ARB_RESET   = 3'd4
  } dbg_arb_state_e;

  // Bits needed to hold max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dbg_bus_arbiter_pulse_cnt.sv
// dbg_pulse_cnt: loadable down-counter with a zero flag.
// Used by the arbiter for both the drain timeout and the core reset pulse.
// Ports:
//   clk, rst_n   clock and async active-low reset (counter clears to 0)
//   i_load       load i_load_val this cycle (wins over i_dec)
//   i_load_val   value to load
//   i_dec        decrement; the count saturates at zero
//   o_zero       count is zero
module dbg_pulse_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dbg_bus_arbiter.sv
// dbg_bus_arbiter: shares the data-memory bus and the register-file debug
// port between the CPU pipeline and the JTAG debug module (DM). Debug
// accesses hold the pipeline, wait for it to drain (bounded by a timeout)
// and then hand the bus to the DM. DM reset requests become a timed,
// active-low core reset pulse.
// Ports:
//   clk, rst_n                      system clock, async active-low reset
//   dm_op_req_i/halt/reset_req      level requests from the DM
//   dm_mem_*                        DM memory port (we/addr/wdata in, rdata out)
//   dm_reg_*                        DM register port (we/addr/wdata in, rdata out)
//   core_mem_*                      core memory request, grant and read data
//   core_idle_i                     pipeline drained, nothing outstanding
//   core_hold_o                     stall the pipeline
//   core_rst_n_o                    active-low core reset (registered)
//   bus_*                           shared memory bus
//   rf_*                            register-file debug port
//   dbg_granted_o                   DM currently owns the bus
//   drain_timeout_o                 sticky: a grant was forced by the timeout
//
// state   | meaning
// IDLE    | core owns the bus, no hold
// DRAIN   | pipeline held, core finishes in-flight accesses
// DEBUG   | DM owns the bus and the register-file write port
// RELEASE | one-cycle guard, nobody owns the bus
// RESET   | core reset pulse; extended while the DM keeps requesting
module dbg_bus_arbiter
  import dbg_bus_arbiter_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int DRAIN_TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dm_op_req_i,
  input  logic                    dm_halt_req_i,
  input  logic                    dm_reset_req_i,
  input  logic                    dm_mem_we_i,
  input  logic [MEM_ADDR_BUS-1:0] dm_mem_addr_i,
  input  logic [MEM_BUS-1:0]      dm_mem_wdata_i,
  output logic [MEM_BUS-1:0]      dm_mem_rdata_o,
  input  logic                    dm_reg_we_i,
  input  logic [REG_ADDR_BUS-1:0] dm_reg_addr_i,
  input  logic [MEM_BUS-1:0]      dm_reg_wdata_i,
  output logic [MEM_BUS-1:0]      dm_reg_rdata_o,
  input  logic                    core_mem_req_i,
  input  logic                    core_mem_we_i,
  input  logic [MEM_ADDR_BUS-1:0] core_mem_addr_i,
  input  logic [MEM_BUS-1:0]      core_mem_wdata_i,
  output logic                    core_mem_gnt_o,
  output logic [MEM_BUS-1:0]      core_mem_rdata_o,
  input  logic                    core_idle_i,
  output logic                    core_hold_o,
  output logic                    core_rst_n_o,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [MEM_ADDR_BUS-1:0] bus_addr_o,
  output logic [MEM_BUS-1:0]      bus_wdata_o,
  input  logic [MEM_BUS-1:0]      bus_rdata_i,
  output logic                    rf_we_o,
  output logic [REG_ADDR_BUS-1:0] rf_addr_o,
  output logic [MEM_BUS-1:0]      rf_wdata_o,
  input  logic [MEM_BUS-1:0]      rf_rdata_i,
  output logic                    dbg_granted_o,
  output logic                    drain_timeout_o
);

  localparam int RST_CNT_W = cnt_width(RST_PULSE_CYCLES - 1);
  localparam logic [RST_CNT_W-1:0]   RST_LOAD   = RST_CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_TIMEOUT);

  dbg_arb_state_e r_state;
  dbg_arb_state_e w_state_nxt;
  logic           r_core_rst_n;
  logic           r_drain_timeout;
  logic           w_any_op;
  logic           w_force_grant;
  logic           w_drain_zero;
  logic           w_rst_zero;
  logic           w_drain_load;
  logic           w_rst_load;
  logic           w_core_owns;
  logic           w_dm_owns;
  logic           w_bus_req;

  assign w_any_op = dm_op_req_i | dm_halt_req_i;

  always_comb begin
    w_state_nxt   = r_state;
    w_force_grant = 1'b0;
    case (r_state)
      DBG_ARB_IDLE: begin
        if (dm_reset_req_i)  w_state_nxt = DBG_ARB_RESET;
        else if (w_any_op)   w_state_nxt = DBG_ARB_DRAIN;
      end
      DBG_ARB_DRAIN: begin
        if (dm_reset_req_i) begin
          w_state_nxt = DBG_ARB_RESET;
        end else if (core_idle_i) begin
          w_state_nxt = DBG_ARB_DEBUG;
        end else if (w_drain_zero) begin
          w_state_nxt   = DBG_ARB_DEBUG;
          w_force_grant = 1'b1;
        end
      end
      DBG_ARB_DEBUG: begin
        if (dm_reset_req_i)  w_state_nxt = DBG_ARB_RESET;
        else if (!w_any_op)  w_state_nxt = DBG_ARB_RELEASE;
      end
      DBG_ARB_RELEASE: w_state_nxt = DBG_ARB_IDLE;
      DBG_ARB_RESET: begin
        // A held request keeps the core in reset past the minimum width.
        if (w_rst_zero && !dm_reset_req_i)
          w_state_nxt = w_any_op ? DBG_ARB_DRAIN : DBG_ARB_IDLE;
      end
      default: w_state_nxt = DBG_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= DBG_ARB_IDLE;
      r_core_rst_n    <= 1'b0;
      r_drain_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_core_rst_n <= (w_state_nxt != DBG_ARB_RESET);
      if (w_force_grant) r_drain_timeout <= 1'b1;
    end
  end

  // Counters are loaded on the edge that enters their state, so the first
  // cycle spent in DRAIN/RESET already sees the full load value.
  assign w_drain_load = (w_state_nxt == DBG_ARB_DRAIN) && (r_state != DBG_ARB_DRAIN);
  assign w_rst_load   = (w_state_nxt == DBG_ARB_RESET) && (r_state != DBG_ARB_RESET);

  dbg_pulse_cnt #(.W(DRAIN_CNT_W)) u_drain_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_drain_load),
    .i_load_val (DRAIN_LOAD),
    .i_dec      (r_state == DBG_ARB_DRAIN),
    .o_zero     (w_drain_zero)
  );

  dbg_pulse_cnt #(.W(RST_CNT_W)) u_rst_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_rst_load),
    .i_load_val (RST_LOAD),
    .i_dec      (r_state == DBG_ARB_RESET),
    .o_zero     (w_rst_zero)
  );

  // RELEASE and RESET belong to neither side, which keeps the two grants
  // from ever overlapping.
  assign w_core_owns = (r_state == DBG_ARB_IDLE) || (r_state == DBG_ARB_DRAIN);
  assign w_dm_owns   = (r_state == DBG_ARB_DEBUG);

  assign w_bus_req   = w_dm_owns ? dm_op_req_i : (w_core_owns & core_mem_req_i);

  assign bus_req_o   = w_bus_req;
  assign bus_we_o    = w_bus_req & (w_dm_owns ? dm_mem_we_i : core_mem_we_i);
  assign bus_addr_o  = w_dm_owns ? dm_mem_addr_i  : core_mem_addr_i;
  assign bus_wdata_o = w_dm_owns ? dm_mem_wdata_i : core_mem_wdata_i;

  assign core_mem_gnt_o   = w_core_owns & core_mem_req_i;
  assign core_mem_rdata_o = bus_rdata_i;
  assign dm_mem_rdata_o   = bus_rdata_i;

  assign rf_we_o        = dm_reg_we_i & w_dm_owns;
  assign rf_addr_o      = dm_reg_addr_i;
  assign rf_wdata_o     = dm_reg_wdata_i;
  assign dm_reg_rdata_o = rf_rdata_i;

  assign core_hold_o     = (r_state != DBG_ARB_IDLE);
  assign dbg_granted_o   = w_dm_owns;
  assign core_rst_n_o    = r_core_rst_n;
  assign drain_timeout_o = r_drain_timeout;

endmodule

// File: tb/tb_dbg_bus_arbiter.sv
module tb_dbg_bus_arbiter;

  localparam int DT = 8;
  localparam int RP = 16;

  logic        clk;
  logic        rst_n;
  logic        dm_op_req_i, dm_halt_req_i, dm_reset_req_i;
  logic        dm_mem_we_i;
  logic [31:0] dm_mem_addr_i, dm_mem_wdata_i, dm_mem_rdata_o;
  logic        dm_reg_we_i;
  logic [4:0]  dm_reg_addr_i;
  logic [31:0] dm_reg_wdata_i, dm_reg_rdata_o;
  logic        core_mem_req_i, core_mem_we_i;
  logic [31:0] core_mem_addr_i, core_mem_wdata_i;
  logic        core_mem_gnt_o;
  logic [31:0] core_mem_rdata_o;
  logic        core_idle_i, core_hold_o, core_rst_n_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_wdata_o, rf_rdata_i;
  logic        dbg_granted_o, drain_timeout_o;

  dbg_bus_arbiter #(.RST_PULSE_CYCLES(RP), .DRAIN_TIMEOUT(DT)) dut (
    .clk(clk), .rst_n(rst_n),
    .dm_op_req_i(dm_op_req_i), .dm_halt_req_i(dm_halt_req_i), .dm_reset_req_i(dm_reset_req_i),
    .dm_mem_we_i(dm_mem_we_i), .dm_mem_addr_i(dm_mem_addr_i), .dm_mem_wdata_i(dm_mem_wdata_i),
    .dm_mem_rdata_o(dm_mem_rdata_o),
    .dm_reg_we_i(dm_reg_we_i), .dm_reg_addr_i(dm_reg_addr_i), .dm_reg_wdata_i(dm_reg_wdata_i),
    .dm_reg_rdata_o(dm_reg_rdata_o),
    .core_mem_req_i(core_mem_req_i), .core_mem_we_i(core_mem_we_i),
    .core_mem_addr_i(core_mem_addr_i), .core_mem_wdata_i(core_mem_wdata_i),
    .core_mem_gnt_o(core_mem_gnt_o), .core_mem_rdata_o(core_mem_rdata_o),
    .core_idle_i(core_idle_i), .core_hold_o(core_hold_o), .core_rst_n_o(core_rst_n_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_wdata_o(rf_wdata_o), .rf_rdata_i(rf_rdata_i),
    .dbg_granted_o(dbg_granted_o), .drain_timeout_o(drain_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the bus, plus elapsed-cycle counts per phase.
  typedef enum int {PH_CORE, PH_WAIT, PH_DM, PH_GUARD, PH_CRST} ph_e;
  ph_e m_ph;
  int  m_wait_cyc;
  int  m_rst_cyc;
  bit  m_sticky;
  bit  m_rst_out;

  task automatic model_reset();
    m_ph = PH_CORE; m_wait_cyc = 0; m_rst_cyc = 0; m_sticky = 0; m_rst_out = 0;
  endtask

  task automatic model_edge();
    bit any_op;
    any_op = dm_op_req_i | dm_halt_req_i;
    case (m_ph)
      PH_CORE: begin
        if (dm_reset_req_i) begin m_ph = PH_CRST; m_rst_cyc = 1; end
        else if (any_op) begin m_ph = PH_WAIT; m_wait_cyc = 1; end
      end
      PH_WAIT: begin
        if (dm_reset_req_i) begin m_ph = PH_CRST; m_rst_cyc = 1; end
        else if (core_idle_i) m_ph = PH_DM;
        else if (m_wait_cyc >= DT + 1) begin m_ph = PH_DM; m_sticky = 1; end
        else m_wait_cyc++;
      end
      PH_DM: begin
        if (dm_reset_req_i) begin m_ph = PH_CRST; m_rst_cyc = 1; end
        else if (!any_op) m_ph = PH_GUARD;
      end
      PH_GUARD: m_ph = PH_CORE;
      default: begin
        if (m_rst_cyc >= RP && !dm_reset_req_i) begin
          m_ph = any_op ? PH_WAIT : PH_CORE;
          m_wait_cyc = 1;
        end else begin
          m_rst_cyc++;
        end
      end
    endcase
    m_rst_out = (m_ph != PH_CRST);
  endtask

  task automatic check_outputs();
    bit e_core, e_dm, e_req;
    e_core = (m_ph == PH_CORE) || (m_ph == PH_WAIT);
    e_dm   = (m_ph == PH_DM);
    e_req  = e_dm ? dm_op_req_i : (e_core & core_mem_req_i);
    check_val("hold",     32'(core_hold_o),     32'(m_ph != PH_CORE));
    check_val("granted",  32'(dbg_granted_o),   32'(e_dm));
    check_val("core_rst", 32'(core_rst_n_o),    32'(m_rst_out));
    check_val("sticky",   32'(drain_timeout_o), 32'(m_sticky));
    check_val("core_gnt", 32'(core_mem_gnt_o),  32'(e_core & core_mem_req_i));
    check_val("bus_req",  32'(bus_req_o),       32'(e_req));
    check_val("bus_addr", bus_addr_o,  e_dm ? dm_mem_addr_i  : core_mem_addr_i);
    check_val("bus_wdat", bus_wdata_o, e_dm ? dm_mem_wdata_i : core_mem_wdata_i);
    if (e_req) check_val("bus_we", 32'(bus_we_o), 32'(e_dm ? dm_mem_we_i : core_mem_we_i));
    check_val("rf_we",    32'(rf_we_o),         32'(dm_reg_we_i & e_dm));
    check_val("rf_addr",  32'(rf_addr_o),       32'(dm_reg_addr_i));
    check_val("both_own", 32'(dbg_granted_o & core_mem_gnt_o), 32'(0));
    check_val("dm_rdata", dm_mem_rdata_o,   bus_rdata_i);
    check_val("c_rdata",  core_mem_rdata_o, bus_rdata_i);
    check_val("rf_rdata", dm_reg_rdata_o,   rf_rdata_i);
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w;
    rst_n = 1'b0;
    dm_op_req_i = 0; dm_halt_req_i = 0; dm_reset_req_i = 0;
    dm_mem_we_i = 0; dm_mem_addr_i = 0; dm_mem_wdata_i = 0;
    dm_reg_we_i = 0; dm_reg_addr_i = 0; dm_reg_wdata_i = 0;
    core_mem_req_i = 0; core_mem_we_i = 0; core_mem_addr_i = 32'h40; core_mem_wdata_i = 32'h55;
    core_idle_i = 0; bus_rdata_i = 32'hA5A5_0001; rf_rdata_i = 32'h0BAD_F00D;
    model_reset();

    #3;
    check_val("rst_hold",     32'(core_hold_o),     32'(0));
    check_val("rst_granted",  32'(dbg_granted_o),   32'(0));
    check_val("rst_core_rst", 32'(core_rst_n_o),    32'(0));
    check_val("rst_sticky",   32'(drain_timeout_o), 32'(0));
    @(posedge clk); #1;
    check_val("rst_core_rst_held", 32'(core_rst_n_o), 32'(0));
    rst_n = 1'b1;
    step();
    check_val("core_rst_release", 32'(core_rst_n_o), 32'(1));

    // 1: op request with idle core -> hold after 1, grant after 2
    core_idle_i = 1; core_mem_req_i = 1;
    dm_mem_addr_i = 32'h100; dm_mem_wdata_i = 32'hDEADBEEF; dm_mem_we_i = 1; dm_op_req_i = 1;
    step();
    check_val("t1_hold_1cyc",  32'(core_hold_o),   32'(1));
    check_val("t1_no_grant",   32'(dbg_granted_o), 32'(0));
    step();
    check_val("t1_grant_2cyc", 32'(dbg_granted_o), 32'(1));
    check_val("t1_bus_addr",   bus_addr_o,  32'h100);
    check_val("t1_bus_wdata",  bus_wdata_o, 32'hDEADBEEF);
    check_val("t1_bus_we",     32'(bus_we_o),       32'(1));
    check_val("t1_core_gnt",   32'(core_mem_gnt_o), 32'(0));

    // 3: register writes pass only while the DM is granted
    dm_reg_we_i = 1; dm_reg_addr_i = 5; dm_reg_wdata_i = 32'h1234;
    #1;
    check_val("t3_rf_we",    32'(rf_we_o),   32'(1));
    check_val("t3_rf_addr",  32'(rf_addr_o), 32'(5));
    check_val("t3_rf_wdata", rf_wdata_o,     32'h1234);
    dm_reg_we_i = 0; dm_op_req_i = 0; dm_mem_we_i = 0;
    step();
    check_val("t3_release_hold", 32'(core_hold_o), 32'(1));
    step();
    check_val("t3_idle_hold", 32'(core_hold_o), 32'(0));
    dm_reg_we_i = 1;
    #1;
    check_val("t3_rf_we_idle", 32'(rf_we_o), 32'(0));
    dm_reg_we_i = 0;

    // 2: drain timeout with core never idle
    core_idle_i = 0; dm_halt_req_i = 1;
    n = 0;
    do begin step(); n++; end while (!dbg_granted_o && n < 40);
    check_val("t2_grant_cycle", 32'(n), 32'(DT + 2));
    check_val("t2_sticky", 32'(drain_timeout_o), 32'(1));
    dm_halt_req_i = 0;
    step(); step();
    check_val("t2_sticky_after", 32'(drain_timeout_o), 32'(1));
    check_val("t2_idle_hold", 32'(core_hold_o), 32'(0));

    // 4: reset pulse width, single-cycle and held
    dm_reset_req_i = 1;
    step();
    dm_reset_req_i = 0;
    w = core_rst_n_o ? 0 : 1;
    n = 0;
    while (!core_rst_n_o && n < 100) begin step(); n++; if (!core_rst_n_o) w++; end
    check_val("t4_pulse_width", 32'(w), 32'(RP));
    dm_reset_req_i = 1; w = 0;
    for (int i = 0; i < 40; i++) begin step(); if (!core_rst_n_o) w++; end
    dm_reset_req_i = 0;
    n = 0;
    while (!core_rst_n_o && n < 100) begin step(); n++; if (!core_rst_n_o) w++; end
    check_val("t4_held_width", 32'(w), 32'(40));
    check_val("t4_back_idle",  32'(core_hold_o), 32'(0));

    // 5: reset request during DRAIN with halt still high
    dm_halt_req_i = 1; core_idle_i = 0;
    step(); step(); step();
    dm_reset_req_i = 1;
    step();
    dm_reset_req_i = 0;
    check_val("t5_in_reset", 32'(core_rst_n_o), 32'(0));
    n = 0;
    while (!core_rst_n_o && n < 100) begin step(); n++; end
    check_val("t5_drain_hold",  32'(core_hold_o),   32'(1));
    check_val("t5_drain_nogrt", 32'(dbg_granted_o), 32'(0));
    core_idle_i = 1;
    step();
    check_val("t5_debug", 32'(dbg_granted_o), 32'(1));
    dm_halt_req_i = 0;
    step(); step();

    // 6: rst_n asserted mid-DEBUG
    dm_op_req_i = 1;
    step(); step();
    check_val("t6_in_debug", 32'(dbg_granted_o), 32'(1));
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check_val("t6_hold",     32'(core_hold_o),     32'(0));
    check_val("t6_granted",  32'(dbg_granted_o),   32'(0));
    check_val("t6_core_rst", 32'(core_rst_n_o),    32'(0));
    check_val("t6_sticky",   32'(drain_timeout_o), 32'(0));
    model_reset();
    dm_op_req_i = 0;
    @(posedge clk); #1;
    rst_n = 1;
    step();
    check_val("t6_core_rst_back", 32'(core_rst_n_o), 32'(1));

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0)  dm_op_req_i   = ~dm_op_req_i;
      if ($urandom_range(15) == 0) dm_halt_req_i = ~dm_halt_req_i;
      if ($urandom_range(5) == 0)  core_idle_i   = ~core_idle_i;
      dm_reset_req_i   = ($urandom_range(59) == 0);
      dm_mem_we_i      = $urandom_range(1);
      dm_mem_addr_i    = $urandom;
      dm_mem_wdata_i   = $urandom;
      dm_reg_we_i      = $urandom_range(1);
      dm_reg_addr_i    = 5'($urandom_range(31));
      dm_reg_wdata_i   = $urandom;
      core_mem_req_i   = $urandom_range(1);
      core_mem_we_i    = $urandom_range(1);
      core_mem_addr_i  = $urandom;
      core_mem_wdata_i = $urandom;
      bus_rdata_i      = $urandom;
      rf_rdata_i       = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
